vx_fifo_queue: RTL and testbench



---
 rtl/vx_fifo_pkg.sv | 10 +
 rtl/vx_pending_size.sv | 31 +++
 rtl/vx_fifo_queue.sv | 68 ++++++
 tb/tb_vx_fifo_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vx_fifo_pkg.sv
// vx_fifo_pkg: width helpers and default thresholds shared by the FIFO slice.
package vx_fifo_pkg;
  localparam int DEF_ALM_EMPTY = 1;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int size_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vx_pending_size.sv
// vx_pending_size: occupancy counter with registered empty/full flags.
module vx_pending_size
  import vx_fifo_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int SIZEW = size_w(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [SIZEW-1:0] size
);
  logic pop_e, push_e;
  logic [SIZEW-1:0] size_n;
  assign pop_e  = pop && !empty;
  assign push_e = push && (!full || pop_e);
  assign size_n = size + SIZEW'(push_e) - SIZEW'(pop_e);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      size  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      size  <= size_n;
      empty <= size_n == '0;
      full  <= size_n == SIZEW'(SIZE);
    end
endmodule

// File: rtl/vx_fifo_queue.sv
// vx_fifo_queue: show-ahead FIFO with registered occupancy flags.
// Define VX_FIFO_CHECK_EN to flag overflow/underflow attempts in simulation.
module vx_fifo_queue
  import vx_fifo_pkg::*;
#(
  parameter int DATAW     = 1,
  parameter int SIZE      = 2,
  parameter int ALM_FULL  = SIZE - 1,
  parameter int ALM_EMPTY = DEF_ALM_EMPTY,
  parameter int ADDRW     = addr_w(SIZE),
  parameter int SIZEW     = size_w(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             alm_empty,
  output logic             alm_full,
  output logic [SIZEW-1:0] size
);
  logic pop_e, push_e;
  logic [SIZEW-1:0] size_n;
  assign pop_e  = pop && !empty;
  assign push_e = push && (!full || pop_e);
  assign size_n = size + SIZEW'(push_e) - SIZEW'(pop_e);
  vx_pending_size #(.SIZE(SIZE), .SIZEW(SIZEW)) u_size (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .empty(empty), .full(full), .size(size)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      alm_empty <= 1'b1;
      alm_full  <= ALM_FULL == 0;
    end else begin
      alm_empty <= int'(size_n) <= ALM_EMPTY;
      alm_full  <= int'(size_n) >= ALM_FULL;
    end
  if (SIZE == 1) begin : g_one
    logic [DATAW-1:0] ent;
    always_ff @(posedge clk)
      if (push_e) ent <= data_in;
    assign data_out = empty ? '0 : ent;
  end else begin : g_ram
    logic [DATAW-1:0] mem [SIZE];
    logic [ADDRW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk)
      if (push_e) mem[wr_ptr] <= data_in;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_e) wr_ptr <= (wr_ptr == ADDRW'(SIZE - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop_e) rd_ptr <= (rd_ptr == ADDRW'(SIZE - 1)) ? '0 : rd_ptr + 1'b1;
      end
    assign data_out = empty ? '0 : mem[rd_ptr];
  end
`ifdef VX_FIFO_CHECK_EN
  always @(posedge clk) begin
    if (reset && push && full && !pop) $error("vx_fifo_queue: push while full");
    if (reset && pop && empty) $error("vx_fifo_queue: pop while empty");
  end
`endif
endmodule

// File: tb/tb_vx_fifo_queue.sv
// tb_vx_fifo_queue: directed checks of the FIFO (SIZE=4 and SIZE=3) and vx_pending_size.
module tb_vx_fifo_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic c_reset = 1'b1;
  always #5 clk = ~clk;

  logic a_push = 0, a_pop = 0;
  logic [7:0] a_din = 0, a_dout;
  logic a_empty, a_full, a_ae, a_af;
  logic [2:0] a_size;
  vx_fifo_queue #(.DATAW(8), .SIZE(4)) dut_a (
    .clk(clk), .reset(rst_n), .push(a_push), .pop(a_pop), .data_in(a_din),
    .data_out(a_dout), .empty(a_empty), .full(a_full), .alm_empty(a_ae),
    .alm_full(a_af), .size(a_size)
  );

  logic b_push = 0, b_pop = 0;
  logic [7:0] b_din = 0, b_dout;
  logic b_empty, b_full, b_ae, b_af;
  logic [1:0] b_size;
  vx_fifo_queue #(.DATAW(8), .SIZE(3)) dut_b (
    .clk(clk), .reset(rst_n), .push(b_push), .pop(b_pop), .data_in(b_din),
    .data_out(b_dout), .empty(b_empty), .full(b_full), .alm_empty(b_ae),
    .alm_full(b_af), .size(b_size)
  );

  logic c_push = 0, c_pop = 0, c_empty, c_full;
  logic [1:0] c_size;
  vx_pending_size #(.SIZE(2)) dut_c (
    .clk(clk), .reset(c_reset), .push(c_push), .pop(c_pop),
    .empty(c_empty), .full(c_full), .size(c_size)
  );

  int checks = 0, errors = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apush(input logic [7:0] d);
    a_push = 1; a_pop = 0; a_din = d;
    tick();
    a_push = 0;
  endtask

  initial begin
    #2 rst_n = 0; c_reset = 0;
    #1;
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_size", a_size, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_alm_empty", a_ae, 1);
    chk("rst_alm_full", a_af, 0);
    tick();
    rst_n = 1; c_reset = 1;
    tick();
    chk("idle_empty", a_empty, 1);
    chk("idle_dout", a_dout, 0);
    // fill to full
    apush(8'h11);
    chk("p1_dout", a_dout, 8'h11);
    chk("p1_empty", a_empty, 0);
    chk("p1_alm_empty", a_ae, 1);
    apush(8'h22);
    chk("p2_alm_empty", a_ae, 0);
    chk("p2_dout", a_dout, 8'h11);
    apush(8'h33);
    chk("p3_alm_full", a_af, 1);
    chk("p3_full", a_full, 0);
    apush(8'h44);
    chk("p4_full", a_full, 1);
    chk("p4_size", a_size, 4);
    chk("p4_alm_full", a_af, 1);
    apush(8'h55);
    chk("ovf_size", a_size, 4);
    chk("ovf_dout", a_dout, 8'h11);
    // drain
    a_pop = 1;
    tick(); chk("pop1_dout", a_dout, 8'h22);
    chk("pop1_full", a_full, 0);
    tick(); chk("pop2_dout", a_dout, 8'h33);
    tick(); chk("pop3_dout", a_dout, 8'h44);
    tick(); chk("pop4_empty", a_empty, 1);
    chk("pop4_dout", a_dout, 0);
    tick(); chk("unf_size", a_size, 0);
    chk("unf_empty", a_empty, 1);
    a_pop = 0;
    // push+pop at size 2
    apush(8'hA1); apush(8'hA2);
    a_push = 1; a_pop = 1; a_din = 8'hA3;
    tick();
    chk("pp2_size", a_size, 2);
    chk("pp2_dout", a_dout, 8'hA2);
    a_push = 0;
    tick(); chk("pp2_next", a_dout, 8'hA3);
    tick(); chk("pp2_drain", a_empty, 1);
    a_pop = 0;
    // push+pop when full
    apush(8'hB1); apush(8'hB2); apush(8'hB3); apush(8'hB4);
    a_push = 1; a_pop = 1; a_din = 8'hB5;
    tick();
    chk("ppf_size", a_size, 4);
    chk("ppf_full", a_full, 1);
    chk("ppf_dout", a_dout, 8'hB2);
    a_push = 0;
    tick(); chk("ppf_d3", a_dout, 8'hB3);
    tick(); chk("ppf_d4", a_dout, 8'hB4);
    tick(); chk("ppf_d5", a_dout, 8'hB5);
    tick(); chk("ppf_empty", a_empty, 1);
    // push+pop when empty
    a_push = 1; a_pop = 1; a_din = 8'hC1;
    tick();
    chk("ppe_size", a_size, 1);
    chk("ppe_dout", a_dout, 8'hC1);
    a_push = 0;
    tick(); chk("ppe_drain", a_empty, 1);
    a_pop = 0;
    // wrap-around on SIZE=3
    b_push = 1; b_din = 8'h01; tick(); q.push_back(8'h01);
    b_din = 8'h02; tick(); q.push_back(8'h02);
    b_pop = 1;
    for (int r = 0; r < 10; r++) begin
      chk("wrap_dout", b_dout, q[0]);
      b_din = 8'(r * 7 + 3);
      tick();
      void'(q.pop_front());
      q.push_back(8'(r * 7 + 3));
      chk("wrap_size", b_size, 2);
    end
    b_push = 0;
    chk("wrap_last0", b_dout, q[0]);
    tick();
    chk("wrap_last1", b_dout, q[1]);
    tick();
    chk("wrap_empty", b_empty, 1);
    b_pop = 0;
    // stand-alone counter
    c_push = 1;
    tick(); chk("pend_size1", c_size, 1);
    chk("pend_full1", c_full, 0);
    tick(); chk("pend_full2", c_full, 1);
    c_pop = 1;
    tick(); chk("pend_pp_full", c_full, 1);
    chk("pend_pp_size", c_size, 2);
    c_push = 0; c_pop = 0;
    #2 c_reset = 0;
    #1;
    chk("pend_rst_size", c_size, 0);
    chk("pend_rst_empty", c_empty, 1);
    c_reset = 1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
